spi_master_ctrl: RTL and testbench

//  Single-clock SPI master; the host-side stage driving spi_wrapper's MOSI/SS_n and consuming MISO.

---
 rtl/spi_master_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//
// Host-side SPI master. It turns host commands into serial frames on
// MOSI/SS_n, one bit per clk. For a read-data command it captures the byte
// the slave returns on MISO. That byte goes back to the host with a
// one-cycle rsp_valid pulse.
//
// Frame word W[9:0] = {cmd_type, cmd_data}. For type 2'b11, W[7:0] is forced
// to 8'h00.
//
// State sequence:
//   IDLE -> LEAD -> SHIFT -> (type 11: WAIT -> CAPT) -> END -> GAP -> IDLE
//
// SS_n is low for LEAD, SHIFT, WAIT and CAPT:
//   11 cycles for types 00/01/10
//   19+RD_WAIT cycles for type 11
//
// Parameters
//   RD_WAIT : idle cycles between the last MOSI bit of a read-data frame and
//             the first MISO sample
//   SS_GAP  : cycles SS_n stays high between frames, counting END (>= 1)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   cmd_valid  in   host command request
//   cmd_ready  out  a command is accepted at the next edge if cmd_valid
//   cmd_type   in   00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data   in   address/data byte (ignored for type 11)
//   rsp_valid  out  one-cycle pulse, rsp_data holds a new read byte
//   rsp_data   out  last byte captured from MISO
//   busy       out  high from acceptance until the inter-frame gap elapsed
//   MOSI       out  serial data to slave, MSB first
//   SS_n       out  slave select, active low
//   MISO       in   serial data from slave
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int RD_WAIT = 2,
    parameter int SS_GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO
);

    // One down-counter is shared by SHIFT, WAIT, CAPT and GAP. It must hold
    // the largest reload value any of them needs.
    localparam int CNT_MAX0 = (RD_WAIT > SS_GAP) ? RD_WAIT : SS_GAP;
    localparam int CNT_MAX  = (CNT_MAX0 > 10) ? CNT_MAX0 : 10;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_END   = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [9:0]       word_q,  word_d;
    // Only the first seven MISO bits are stored here. The eighth bit is
    // taken straight from MISO on the edge that closes the last CAPT cycle.
    logic [6:0]       rx_q,    rx_d;

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    logic       ss_n_q,      ss_n_d;
    logic       mosi_q,      mosi_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       busy_q,      busy_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q,  rsp_data_d;

    logic       accept;
    logic [9:0] frame_word;
    logic       in_frame_d;
    logic       last_gap_d;

    // cmd_ready is registered, so a handshake uses the value visible to the
    // host during the current cycle.
    assign accept     = cmd_valid && cmd_ready_q;
    assign frame_word = {cmd_type, (cmd_type == 2'b11) ? 8'h00 : cmd_data};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            rx_q    <= rx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rx_d    = rx_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LEAD;
                    word_d  = frame_word;
                end
            end

            S_LEAD: begin
                state_d = S_SHIFT;
                cnt_d   = CNT_W'(9);
            end

            S_SHIFT: begin
                if (cnt_q == '0) begin
                    if (word_q[9:8] == 2'b11) begin
                        if (RD_WAIT > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(RD_WAIT - 1);
                        end else begin
                            state_d = S_CAPT;
                            cnt_d   = CNT_W'(7);
                        end
                    end else begin
                        state_d = S_END;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPT;
                    cnt_d   = CNT_W'(7);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_CAPT: begin
                rx_d = {rx_q[5:0], MISO};
                if (cnt_q == '0) begin
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_END: begin
                // END counts as the first gap cycle. With a one-cycle gap,
                // the next command can be taken directly from here.
                if (SS_GAP > 1) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(SS_GAP - 2);
                end else if (accept) begin
                    state_d = S_LEAD;
                    word_d  = frame_word;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    if (accept) begin
                        state_d = S_LEAD;
                        word_d  = frame_word;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    // Outputs are decoded from the next state and then registered. Each
    // output therefore matches the state it belongs to during the same cycle.
    always_comb begin
        in_frame_d = (state_d == S_LEAD) || (state_d == S_SHIFT) ||
                     (state_d == S_WAIT) || (state_d == S_CAPT);

        // cmd_ready rises in the final gap cycle. This lets a held cmd_valid
        // start the next frame with no bubble beyond SS_GAP.
        last_gap_d = ((state_d == S_END) && (SS_GAP == 1)) ||
                     ((state_d == S_GAP) && (cnt_d == '0));

        ss_n_d      = !in_frame_d;
        cmd_ready_d = (state_d == S_IDLE) || last_gap_d;
        busy_d      = (state_d != S_IDLE);

        mosi_d = 1'b0;
        if (state_d == S_LEAD) begin
            // The lead cycle repeats the selector bit, so the slave can
            // decode read/write before the word itself starts.
            mosi_d = word_d[9];
        end else if (state_d == S_SHIFT) begin
            mosi_d = word_d[cnt_d[3:0]];
        end

        rsp_valid_d = (state_q == S_CAPT) && (state_d == S_END);
        rsp_data_d  = rsp_valid_d ? {rx_q, MISO} : rsp_data_q;
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Directed self-checking bench for spi_master_ctrl (RD_WAIT=2, SS_GAP=1).
//
// Each frame is driven through do_frame. The task performs the handshake and
// records the eleven MOSI bits sent while SS_n is low. It also plays the
// slave side on MISO for read-data frames. Expected bit patterns are
// hand-computed as {W[9], W[9:0]}.
//
// A small address/RAM slave model covers the write-then-read-back loop.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int RD_WAIT = 2;
    localparam int SS_GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;

    int n_vec = 0;
    int n_bad = 0;

    // Slave RAM model used by the write / read-back loop
    logic [7:0] ram [256];
    logic [7:0] slv_wa;
    logic [7:0] slv_ra;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .RD_WAIT (RD_WAIT),
        .SS_GAP  (SS_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO)
    );

    // Advance one cycle and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame, starting just after an edge.
    //   bits  : MOSI during the first 11 SS_n-low cycles, first cycle in MSB
    //   low   : number of SS_n-low cycles
    //   waits : cycles spent waiting for cmd_ready before acceptance
    //   rv_lo : rsp_valid pulses seen while SS_n was low
    // The task returns in the first SS_n-high cycle (END).
    task automatic do_frame(input logic [1:0] t, input logic [7:0] d,
                            input logic [7:0] mb, input bit keep,
                            output logic [10:0] bits, output int low,
                            output int waits, output int rv_lo);
        logic [7:0] sh;
        int k;
        sh       = mb;
        bits     = '0;
        rv_lo    = 0;
        waits    = 0;
        cmd_type  = t;
        cmd_data  = d;
        cmd_valid = 1'b1;
        MISO      = 1'b0;

        while (cmd_ready !== 1'b1 && waits < 40) begin
            tick();
            waits++;
        end
        tick();                          // acceptance edge

        // Disturb the command inputs: the frame in flight must not change.
        cmd_data = ~d;
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_type  = ~t;
        end

        k = 0;
        while (SS_n === 1'b0 && k < 40) begin
            if (k < 11) bits = {bits[9:0], MOSI};
            if (rsp_valid === 1'b1) rv_lo++;
            if (k >= 11 + RD_WAIT && k < 19 + RD_WAIT) begin
                MISO = sh[7];
                sh   = {sh[6:0], 1'b0};
            end else begin
                MISO = 1'b0;
            end
            tick();
            k++;
        end
        MISO = 1'b0;
        low  = k;
        $display("frame type=%b data=%h bits=%h ss_low=%0d waits=%0d rsp_valid=%b rsp_data=%h",
                 t, d, bits, low, waits, rsp_valid, rsp_data);
    endtask

    // Runs a frame and checks everything fixed by the frame shape.
    task automatic frame_chk(input string tag, input logic [1:0] t, input logic [7:0] d,
                             input logic [7:0] mb, input bit keep,
                             input logic [10:0] exp_bits, input int exp_low,
                             output logic [10:0] bits);
        int low, waits, rv_lo;
        do_frame(t, d, mb, keep, bits, low, waits, rv_lo);
        chk({tag, "_bits"},  32'(bits),  32'(exp_bits));
        chk({tag, "_sslow"}, 32'(low),   32'(exp_low));
        chk({tag, "_waits"}, 32'(waits), 32'd0);
        chk({tag, "_rvlow"}, 32'(rv_lo), 32'd0);
        chk({tag, "_ssend"}, 32'(SS_n),  32'd1);
        chk({tag, "_mosiend"}, 32'(MOSI), 32'd0);
    endtask

    // Slave-side decode of a completed frame word (bits[9:0] = W).
    task automatic slave_apply(input logic [10:0] bits);
        case (bits[9:8])
            2'b00:   slv_wa = bits[7:0];
            2'b01:   ram[slv_wa] = bits[7:0];
            2'b10:   slv_ra = bits[7:0];
            default: ;
        endcase
    endtask

    initial begin
        logic [10:0] b;
        int bad;

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        slv_wa    = 8'h00;
        slv_ra    = 8'h00;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_data  = 8'h00;
        MISO      = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ss_n",      32'(SS_n),      32'd1);
        chk("rst_mosi",      32'(MOSI),      32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h00);
        chk("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rel_busy",      32'(busy),      32'd0);

        // ---------------- T1: wr-addr 0x3C, cmd_valid kept for T2 ----------------
        // W = 00_0011_1100 -> {0, W} = 11'h03C
        frame_chk("t1", 2'b00, 8'h3C, 8'h00, 1'b1, 11'h03C, 11, b);
        chk("t1_end_ready", 32'(cmd_ready), 32'd1);
        chk("t1_end_busy",  32'(busy),      32'd1);

        // ---------------- T2: wr-data 0xA5 back to back (1-cycle gap) ----------------
        // W = 01_1010_0101 -> {0, W} = 11'h1A5
        frame_chk("t2", 2'b01, 8'hA5, 8'h00, 1'b0, 11'h1A5, 11, b);
        chk("t2_end_rv", 32'(rsp_valid), 32'd0);
        tick();
        chk("t2_idle_busy",  32'(busy),      32'd0);
        chk("t2_idle_ready", 32'(cmd_ready), 32'd1);
        chk("t2_idle_ss",    32'(SS_n),      32'd1);

        // ---------------- T3: rd-addr 0x3C then rd-data returning 0xA5 ----------------
        // rd-addr W = 10_0011_1100 -> 11'h63C; rd-data W = 11_0000_0000 -> 11'h700
        frame_chk("t3a", 2'b10, 8'h3C, 8'h00, 1'b1, 11'h63C, 11, b);
        // cmd_data 0x77 must be ignored for type 11.
        frame_chk("t3b", 2'b11, 8'h77, 8'hA5, 1'b0, 11'h700, 19 + RD_WAIT, b);
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t3_rsp_data",  32'(rsp_data),  32'hA5);
        tick();
        chk("t3_rv_pulse", 32'(rsp_valid), 32'd0);
        chk("t3_rsp_hold", 32'(rsp_data),  32'hA5);
        chk("t3_busy",     32'(busy),      32'd0);

        // ---------------- T4: write 0x5A to 0x10 then read it back ----------------
        frame_chk("t4wa", 2'b00, 8'h10, 8'h00, 1'b1, 11'h010, 11, b);
        slave_apply(b);
        chk("t4_wr_rv",   32'(rsp_valid), 32'd0);
        chk("t4_wr_hold", 32'(rsp_data),  32'hA5);
        frame_chk("t4wd", 2'b01, 8'h5A, 8'h00, 1'b1, 11'h15A, 11, b);
        slave_apply(b);
        frame_chk("t4ra", 2'b10, 8'h10, 8'h00, 1'b1, 11'h610, 11, b);
        slave_apply(b);
        frame_chk("t4rd", 2'b11, 8'h00, ram[slv_ra], 1'b0, 11'h700, 19 + RD_WAIT, b);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rsp_data",  32'(rsp_data),  32'h5A);
        tick();

        // ---------------- T5: reset during SHIFT bit 4 ----------------
        cmd_type  = 2'b00;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        tick();                          // accept -> LEAD
        cmd_valid = 1'b0;
        repeat (6) tick();               // SHIFT bits 9..4, now on bit 4
        chk("t5_bit4_ss",   32'(SS_n), 32'd0);
        chk("t5_bit4_mosi", 32'(MOSI), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_ss",    32'(SS_n),      32'd1);
        chk("t5_rst_mosi",  32'(MOSI),      32'd0);
        chk("t5_rst_busy",  32'(busy),      32'd0);
        chk("t5_rst_rv",    32'(rsp_valid), 32'd0);
        chk("t5_rst_ready", 32'(cmd_ready), 32'd0);
        chk("t5_rst_data",  32'(rsp_data),  32'h00);
        rst_n = 1'b1;
        tick();
        chk("t5_rel_ready", 32'(cmd_ready), 32'd1);
        chk("t5_rel_rv",    32'(rsp_valid), 32'd0);
        frame_chk("t5", 2'b00, 8'h3C, 8'h00, 1'b0, 11'h03C, 11, b);
        tick();

        // ---------------- T6: quiet idle for 50 cycles ----------------
        cmd_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (SS_n !== 1'b1 || MOSI !== 1'b0 || cmd_ready !== 1'b1 ||
                busy !== 1'b0 || rsp_valid !== 1'b0)
                bad++;
            tick();
        end
        chk("t6_idle_violations", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
